alu_functional_unit: RTL and testbench
======================================

// Module: alu_functional_unit
// PURPOSE
//  Integer ALU execution unit directly downstream of the reservation station.
//  Accepts one issued op per cycle (opcode, two operand values, ROB index) and computes the AluFunc result.
//  Buffers results in a small queue and broadcasts them on the common data bus (CDB) under a req/grant handshake.
//  Drives fu_busy back to the reservation station as issue backpressure.
// PARAMETERS
//  XLEN         32  operand/result width
//  ROB_IDX_W    3   ROB index width (8-entry ROB)
//  RESULT_DEPTH 2   result queue entries awaiting CDB grant (>=2)
// PORTS
//  clk_in           in   1          clock, all state on rising edge
//  rst_n_in         in   1          reset, asynchronous, active-low
//  flush_in         in   1          sync squash (mispredict): drop all in-flight/queued ops
//  valid_in         in   1          issue valid from reservation station
//  opcode_in        in   4          AluFunc encoding
//  rval1_in         in   XLEN       operand 1 (rs1 value)
//  rval2_in         in   XLEN       operand 2 (rs2/imm value)
//  rob_idx_in       in   ROB_IDX_W  destination ROB entry
//  fu_busy_out      out  1          1 = do not issue this cycle
//  cdb_req_out      out  1          queue head valid, requesting CDB
//  cdb_grant_in     in   1          CDB arbiter grant; pops head when cdb_req_out=1
//  cdb_value_out    out  XLEN       head result
//  cdb_rob_idx_out  out  ROB_IDX_W  head ROB index
//  cdb_exc_out      out  1          head op had illegal opcode
// BEHAVIOUR
//  Reset (rst_n_in=0, async): ex_valid=0, queue empty; fu_busy_out=0, cdb_req_out=0, cdb_value_out=0, cdb_rob_idx_out=0, cdb_exc_out=0.
//  Opcodes: Add=0 Sub=1 And=2 Or=3 Xor=4 Slt=5 Sltu=6 Sll=7 Srl=8 Sra=9; 10-15 illegal -> value 0, exc=1.
//  Shifts use rval2[4:0] only; Slt signed, Sltu unsigned, result 0/1 zero-extended; Add/Sub wrap mod 2^XLEN.
//  Stage EX: edge N with valid_in=1 and fu_busy_out=0 latches op into EX reg, ex_valid=1.
//   valid_in while fu_busy_out=1 is ignored (op lost: issuing then is a protocol violation).
//  Stage WB: edge N+1 computes result from EX reg and pushes {value,rob_idx,exc} to queue tail.
//   Min latency: issue at edge N -> cdb_req_out=1 after edge N+1.
//  Queue: FIFO, RESULT_DEPTH entries, ptr wrap mod depth, count 0..RESULT_DEPTH; in-order, no reordering.
//   Outputs show head whenever count>0; cdb_req_out = (count!=0); outputs hold stable until granted.
//   Pop on edge where cdb_req_out && cdb_grant_in; cdb_grant_in with empty queue ignored.
//   Push and pop same edge: count unchanged, both pointers advance (legal when full).
//  fu_busy_out = (count + ex_valid) >= RESULT_DEPTH; from registers only, no comb path from grant/valid.
//   Same-cycle pop is not credited (conservative); guarantees the queue never overflows.
//  Back-to-back issue sustains 1 op/cycle while grants return every cycle.
//  flush_in=1: at edge, ex_valid=0, count=0, ptrs=0; highest priority over issue, push and pop.
//   cdb_req_out=0 the cycle after; a grant coincident with flush has no effect.
//  Reset mid-operation discards all state immediately (async), outputs to reset values.
// STRUCTURE
//  Shared package alu_pkg: AluFunc enum (4-bit), XLEN, ROB_IDX_W, cdb_pkt_t struct {value, rob_idx, exc}.
//  Sub-module alu_core: purely combinational opcode/operand -> {value, exc}; reused by future FUs.
//  Result queue inline (small FIFO); count register + head/tail pointers.
// TESTING
//  Reset: hold rst_n_in=0 mid-stream -> all outputs 0 asynchronously, fu_busy_out=0.
//  Ops: Sub 5-7 -> 0xFFFFFFFE; Sra 0x80000000>>4 -> 0xF8000000; Slt -1<1 -> 1, Sltu -> 0; Sll by 33 -> shift 1.
//  Latency/order: issue rob 1,2,3 back-to-back, grant held 1 -> CDB rob 1,2,3, first req 2 cycles after issue.
//  Backpressure: grant=0, issue 2 ops -> fu_busy_out=1 after 2nd; queue holds rob 4 stable; grant 1 cycle -> busy drops.
//  Illegal opcode 12, rob 5 -> cdb_value_out=0, cdb_exc_out=1, cdb_rob_idx_out=5.
//  Flush with queue full and op in EX plus grant=1 -> next cycle cdb_req_out=0, fu_busy_out=0, nothing delivered.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for ALU functional units.
//   XLEN       operand/result width
//   ROB_IDX_W  reorder-buffer index width
//   alu_func_e 4-bit ALU opcode encoding; codes above AluSra are illegal
//   cdb_pkt_t  one result as broadcast on the common data bus
package alu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_IDX_W = 3;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSlt  = 4'd5,
    AluSltu = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9
  } alu_func_e;

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 exc;
  } cdb_pkt_t;

endpackage

// File: rtl/alu_functional_unit_if.sv
// Issue and CDB signals of the ALU functional unit.
//   issue side : valid_in, opcode_in, rval1_in, rval2_in, rob_idx_in (to FU), fu_busy_out (from FU)
//   CDB side   : cdb_req_out, cdb_value_out, cdb_rob_idx_out, cdb_exc_out (from FU), cdb_grant_in (to FU)
//   slave  : the functional unit
//   master : the reservation station / CDB arbiter environment
interface alu_functional_unit_if;
  import alu_pkg::*;

  logic                 valid_in;
  logic [3:0]           opcode_in;
  logic [XLEN-1:0]      rval1_in;
  logic [XLEN-1:0]      rval2_in;
  logic [ROB_IDX_W-1:0] rob_idx_in;
  logic                 fu_busy_out;
  logic                 cdb_req_out;
  logic                 cdb_grant_in;
  logic [XLEN-1:0]      cdb_value_out;
  logic [ROB_IDX_W-1:0] cdb_rob_idx_out;
  logic                 cdb_exc_out;

  modport slave (
    input  valid_in, opcode_in, rval1_in, rval2_in, rob_idx_in, cdb_grant_in,
    output fu_busy_out, cdb_req_out, cdb_value_out, cdb_rob_idx_out, cdb_exc_out
  );

  modport master (
    output valid_in, opcode_in, rval1_in, rval2_in, rob_idx_in, cdb_grant_in,
    input  fu_busy_out, cdb_req_out, cdb_value_out, cdb_rob_idx_out, cdb_exc_out
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational integer ALU datapath.
//   opcode_i  alu_func_e encoding (10..15 illegal)
//   a_i, b_i  operands; shifts use b_i[4:0] only
//   value_o   result (0 for illegal opcodes)
//   exc_o     1 when the opcode is illegal
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]      opcode_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] value_o,
  output logic            exc_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    value_o = '0;
    exc_o   = 1'b0;
    case (opcode_i)
      AluAdd:  value_o = a_i + b_i;
      AluSub:  value_o = a_i - b_i;
      AluAnd:  value_o = a_i & b_i;
      AluOr:   value_o = a_i | b_i;
      AluXor:  value_o = a_i ^ b_i;
      AluSlt:  value_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      AluSltu: value_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      AluSll:  value_o = a_i << shamt;
      AluSrl:  value_o = a_i >> shamt;
      AluSra:  value_o = $unsigned($signed(a_i) >>> shamt);
      default: exc_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_functional_unit.sv
// Integer ALU execution unit sitting between the reservation station and the CDB.
//   clk_in    clock, all state on rising edge
//   rst_n_in  asynchronous active-low reset
//   flush_in  synchronous squash of the EX stage and the result queue
//   fu_if     issue inputs / busy backpressure and CDB req/grant broadcast (slave modport)
// One op is latched into EX per accepted issue; the following edge computes its result
// and pushes it into a small FIFO whose head is offered on the CDB until granted.
module alu_functional_unit
  import alu_pkg::*;
#(
  parameter int unsigned ResultDepth = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  flush_in,
  alu_functional_unit_if.slave  fu_if
);

  localparam int unsigned PtrW = $clog2(ResultDepth);
  localparam int unsigned CntW = $clog2(ResultDepth + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(ResultDepth - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(ResultDepth);
  localparam logic [OccW-1:0] DepthOcc = OccW'(ResultDepth);

  // EX stage
  logic                 ex_valid_q, ex_valid_d;
  logic [3:0]           ex_op_q, ex_op_d;
  logic [XLEN-1:0]      ex_a_q, ex_a_d;
  logic [XLEN-1:0]      ex_b_q, ex_b_d;
  logic [ROB_IDX_W-1:0] ex_rob_q, ex_rob_d;

  // Result queue
  cdb_pkt_t             mem_q [ResultDepth];
  cdb_pkt_t             mem_d [ResultDepth];
  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [XLEN-1:0]      wb_value;
  logic                 wb_exc;
  cdb_pkt_t             wb_pkt;
  cdb_pkt_t             head_pkt;
  logic [OccW-1:0]      occ;
  logic                 busy;
  logic                 accept;
  logic                 push;
  logic                 pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  alu_core u_alu_core (
    .opcode_i (ex_op_q),
    .a_i      (ex_a_q),
    .b_i      (ex_b_q),
    .value_o  (wb_value),
    .exc_o    (wb_exc)
  );

  assign wb_pkt = '{value: wb_value, rob_idx: ex_rob_q, exc: wb_exc};

  // Busy counts the EX op as already occupying a slot and ignores a same-cycle pop,
  // so it is purely registered and an accepted op always finds room in the queue.
  assign occ  = {1'b0, count_q} + {{CntW{1'b0}}, ex_valid_q};
  assign busy = (occ >= DepthOcc);

  always_comb begin
    accept = fu_if.valid_in && !busy;
    push   = ex_valid_q && !flush_in;
    pop    = (count_q != '0) && fu_if.cdb_grant_in && !flush_in;

    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_rob_d   = ex_rob_q;
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (flush_in) begin
      ex_valid_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      ex_valid_d = accept;
      if (accept) begin
        ex_op_d  = fu_if.opcode_in;
        ex_a_d   = fu_if.rval1_in;
        ex_b_d   = fu_if.rval2_in;
        ex_rob_d = fu_if.rob_idx_in;
      end
      if (push) begin
        mem_d[tail_q] = wb_pkt;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (push && !pop && (count_q != FullCnt)) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rob_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(ResultDepth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_rob_q   <= ex_rob_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  // Outputs read registers only; an empty queue presents all zeros.
  always_comb begin
    head_pkt              = mem_q[head_q];
    fu_if.fu_busy_out     = busy;
    fu_if.cdb_req_out     = (count_q != '0);
    fu_if.cdb_value_out   = '0;
    fu_if.cdb_rob_idx_out = '0;
    fu_if.cdb_exc_out     = 1'b0;
    if (count_q != '0) begin
      fu_if.cdb_value_out   = head_pkt.value;
      fu_if.cdb_rob_idx_out = head_pkt.rob_idx;
      fu_if.cdb_exc_out     = head_pkt.exc;
    end
  end

endmodule

// File: tb/tb_alu_functional_unit.sv
// Self-checking bench for alu_functional_unit: directed literal cases plus randomized
// issue/grant/flush traffic compared every cycle against a queue-based reference model.
module tb_alu_functional_unit;
  import alu_pkg::*;

  localparam int unsigned Depth = 2;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic flush_in = 1'b0;

  alu_functional_unit_if fu_if ();

  alu_functional_unit #(
    .ResultDepth (Depth)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .flush_in (flush_in),
    .fu_if    (fu_if)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic cdb_pkt_t ref_exec(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [2:0] rob);
    cdb_pkt_t    p;
    int unsigned s;
    s         = 32'(b[4:0]);
    p.rob_idx = rob;
    p.exc     = 1'b0;
    p.value   = 32'h0;
    case (op)
      4'd0: p.value = a + b;
      4'd1: p.value = a - b;
      4'd2: p.value = a & b;
      4'd3: p.value = a | b;
      4'd4: p.value = a ^ b;
      4'd5: p.value = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: p.value = (a < b) ? 32'd1 : 32'd0;
      4'd7: p.value = a << s;
      4'd8: p.value = a >> s;
      4'd9: p.value = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: p.exc = 1'b1;
    endcase
    return p;
  endfunction

  logic     m_ex_v = 1'b0;
  cdb_pkt_t m_ex;
  cdb_pkt_t m_q[$];

  initial begin
    forever begin
      logic busy_m;
      @(posedge clk_in or negedge rst_n_in);
      busy_m = (m_q.size() + int'(m_ex_v)) >= int'(Depth);
      if (!rst_n_in) begin
        m_q.delete();
        m_ex_v = 1'b0;
      end else if (flush_in) begin
        m_q.delete();
        m_ex_v = 1'b0;
      end else begin
        if (m_q.size() != 0 && fu_if.cdb_grant_in) void'(m_q.pop_front());
        if (m_ex_v) m_q.push_back(m_ex);
        m_ex_v = fu_if.valid_in && !busy_m;
        if (m_ex_v) m_ex = ref_exec(fu_if.opcode_in, fu_if.rval1_in, fu_if.rval2_in,
                                    fu_if.rob_idx_in);
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk_in);
      chk("busy", 32'(fu_if.fu_busy_out),
          32'((m_q.size() + int'(m_ex_v)) >= int'(Depth)));
      chk("req", 32'(fu_if.cdb_req_out), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("value", fu_if.cdb_value_out, m_q[0].value);
        chk("rob", 32'(fu_if.cdb_rob_idx_out), 32'(m_q[0].rob_idx));
        chk("exc", 32'(fu_if.cdb_exc_out), 32'(m_q[0].exc));
      end else begin
        chk("value_idle", fu_if.cdb_value_out, 32'h0);
        chk("rob_idle", 32'(fu_if.cdb_rob_idx_out), 32'h0);
        chk("exc_idle", 32'(fu_if.cdb_exc_out), 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] rob);
    fu_if.valid_in   = v;
    fu_if.opcode_in  = op;
    fu_if.rval1_in   = a;
    fu_if.rval2_in   = b;
    fu_if.rob_idx_in = rob;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"}, 32'(fu_if.cdb_req_out), 32'h0);
    chk({tag, "_busy"}, 32'(fu_if.fu_busy_out), 32'h0);
    chk({tag, "_value"}, fu_if.cdb_value_out, 32'h0);
    chk({tag, "_rob"}, 32'(fu_if.cdb_rob_idx_out), 32'h0);
    chk({tag, "_exc"}, 32'(fu_if.cdb_exc_out), 32'h0);
  endtask

  // Single op on an empty queue with grant held: req appears two edges after issue.
  task automatic lit(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [2:0] rob,
                     input logic [31:0] exp_v, input logic exp_exc);
    @(negedge clk_in);
    drive(1'b1, op, a, b, rob);
    @(negedge clk_in);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 3'd0);
    chk({name, "_req_early"}, 32'(fu_if.cdb_req_out), 32'h0);
    @(negedge clk_in);
    chk({name, "_req"}, 32'(fu_if.cdb_req_out), 32'h1);
    chk({name, "_value"}, fu_if.cdb_value_out, exp_v);
    chk({name, "_rob"}, 32'(fu_if.cdb_rob_idx_out), 32'(rob));
    chk({name, "_exc"}, 32'(fu_if.cdb_exc_out), 32'(exp_exc));
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] got_rob[$];
    int         sent;

    drive(1'b0, 4'd0, 32'h0, 32'h0, 3'd0);
    fu_if.cdb_grant_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1 chk_outputs_zero("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Opcode literals
    fu_if.cdb_grant_in = 1'b1;
    lit("sub",     4'd1,  32'd5,          32'd7,  3'd0, 32'hFFFF_FFFE, 1'b0);
    lit("sra",     4'd9,  32'h8000_0000,  32'd4,  3'd1, 32'hF800_0000, 1'b0);
    lit("slt",     4'd5,  32'hFFFF_FFFF,  32'd1,  3'd2, 32'h1,         1'b0);
    lit("sltu",    4'd6,  32'hFFFF_FFFF,  32'd1,  3'd3, 32'h0,         1'b0);
    lit("sll33",   4'd7,  32'h1,          32'd33, 3'd4, 32'h2,         1'b0);
    lit("illegal", 4'd12, 32'h1234,       32'h56, 3'd5, 32'h0,         1'b1);

    // Latency and ordering, issuing whenever busy allows
    @(negedge clk_in);
    drive(1'b1, 4'd0, 32'd100, 32'd1, 3'd1);
    sent = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      if (fu_if.cdb_req_out) got_rob.push_back(fu_if.cdb_rob_idx_out);
      if (c == 0) chk("order_req_n", 32'(fu_if.cdb_req_out), 32'h0);
      if (c == 1) chk("order_req_n1", 32'(fu_if.cdb_req_out), 32'h1);
      if (sent < 3 && !fu_if.fu_busy_out) begin
        sent++;
        drive(1'b1, 4'd0, 32'd100, 32'(sent), 3'(sent));
      end else begin
        drive(1'b0, 4'd0, 32'h0, 32'h0, 3'd0);
      end
    end
    chk("order_count", 32'(got_rob.size()), 32'd3);
    for (int i = 0; i < got_rob.size(); i++) chk("order_rob", 32'(got_rob[i]), 32'(i + 1));

    // Backpressure with grant low
    fu_if.cdb_grant_in = 1'b0;
    @(negedge clk_in);
    drive(1'b1, 4'd0, 32'd10, 32'd20, 3'd4);
    @(negedge clk_in);
    drive(1'b1, 4'd3, 32'hF0, 32'h0F, 3'd6);
    @(negedge clk_in);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 3'd0);
    chk("bp_busy", 32'(fu_if.fu_busy_out), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("bp_hold_req", 32'(fu_if.cdb_req_out), 32'h1);
      chk("bp_hold_rob", 32'(fu_if.cdb_rob_idx_out), 32'd4);
      chk("bp_hold_value", fu_if.cdb_value_out, 32'd30);
      chk("bp_hold_busy", 32'(fu_if.fu_busy_out), 32'h1);
    end
    fu_if.cdb_grant_in = 1'b1;
    @(negedge clk_in);
    fu_if.cdb_grant_in = 1'b0;
    chk("bp_release_busy", 32'(fu_if.fu_busy_out), 32'h0);
    chk("bp_next_rob", 32'(fu_if.cdb_rob_idx_out), 32'd6);
    chk("bp_next_value", fu_if.cdb_value_out, 32'hFF);
    fu_if.cdb_grant_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Flush with queue occupied, op in EX and grant asserted
    fu_if.cdb_grant_in = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 3'd1);
    @(negedge clk_in);
    drive(1'b1, 4'd0, 32'd2, 32'd2, 3'd2);
    @(negedge clk_in);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 3'd0);
    chk("flush_pre_busy", 32'(fu_if.fu_busy_out), 32'h1);
    flush_in           = 1'b1;
    fu_if.cdb_grant_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    chk("flush_req", 32'(fu_if.cdb_req_out), 32'h0);
    chk("flush_busy", 32'(fu_if.fu_busy_out), 32'h0);
    repeat (3) begin
      @(negedge clk_in);
      chk("flush_nothing", 32'(fu_if.cdb_req_out), 32'h0);
    end

    // Randomized traffic with one asynchronous reset mid-stream
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_in);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick_operand(),
            pick_operand(), 3'($urandom_range(0, 7)));
      fu_if.cdb_grant_in = ($urandom_range(0, 2) != 0);
      flush_in           = ($urandom_range(0, 40) == 0);
      if (cyc == 200) begin
        #2 rst_n_in = 1'b0;
        #1 chk_outputs_zero("async_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
      end
    end

    @(negedge clk_in);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 3'd0);
    flush_in           = 1'b0;
    fu_if.cdb_grant_in = 1'b1;
    repeat (6) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
